// File: rtl/receive_data_pkg.sv
// Shared constants and state encoding for the receive_data serial capture block.
// Also holds the counter-width helper so the width rule lives in one place.
package receive_data_pkg;

    localparam int RECEIVE_DATA_WIDTH_DEFAULT = 170;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // Counter has to reach WIDTH itself, hence the +1.
    function automatic int rx_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/receive_data.sv
// Serial-to-parallel capture: after a load_sr strobe, shifts WIDTH bits (MSB first) and updates dout once.
// Latency WIDTH cycles from strobe edge; no backpressure. Optional data_valid pulse via RECEIVE_DATA_VALID_EN.
module receive_data
    import receive_data_pkg::*;
#(
    parameter int WIDTH = RECEIVE_DATA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dout_sr,
    input  logic             load_sr,
    output logic [WIDTH-1:0] dout
`ifdef RECEIVE_DATA_VALID_EN
    ,
    output logic             data_valid
`endif
);

    localparam int               CNT_W    = rx_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // The oldest bit of a frame never needs to sit in sr: it goes straight into dout.
    logic [WIDTH-2:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   sr_next;
    logic               frame_done;

    assign sr_next    = {sr_q, dout_sr};
    assign frame_done = (state_q == RX_SHIFT) && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        case (state_q)
            RX_IDLE: begin
                if (load_sr) begin
                    cnt_d   = '0;
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                sr_d  = sr_next[WIDTH-2:0];
                cnt_d = cnt_q + CNT_ONE;
                if (frame_done) begin
                    dout_d  = sr_next;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef RECEIVE_DATA_VALID_EN
    logic data_valid_q, data_valid_d;

    assign data_valid_d = frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= data_valid_d;
        end
    end

    assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_receive_data.sv
// Randomized self-checking bench for receive_data; expected words are assembled from the transmitted bit list.
module tb_receive_data;

    localparam int W = 170;

    logic         clk = 1'b0;
    logic         rst;
    logic         dout_sr;
    logic         load_sr;
    logic [W-1:0] dout;
`ifdef RECEIVE_DATA_VALID_EN
    logic         data_valid;
`endif

    int           errors = 0;
    int           checks = 0;
    logic         tx_bits [W];
    logic [W-1:0] model_dout;

    always #5 clk = ~clk;

    receive_data #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dout_sr    (dout_sr),
        .load_sr    (load_sr),
        .dout       (dout)
`ifdef RECEIVE_DATA_VALID_EN
        ,
        .data_valid (data_valid)
`endif
    );

    // First transmitted bit lands in the MSB.
    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[W-1-i] = tx_bits[i];
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < W; i++) tx_bits[i] = 1'($urandom);
    endtask

    // Strobe, then drive the W bits of tx_bits. restrobe_at pulses load_sr again at that bit index;
    // abort_at asserts rst just before that bit index is shifted (-1 disables either).
    task automatic run_frame(input string name, input bit hold_load, input int restrobe_at, input int abort_at);
        logic [W-1:0] exp_word;
        int           hold_bad;
        int           vld_bad;
        exp_word = model_word();
        hold_bad = 0;
        vld_bad  = 0;
        @(negedge clk);
        load_sr = 1'b1;
        dout_sr = 1'($urandom);
        @(posedge clk);
        #1;
        if (dout !== model_dout) hold_bad++;
`ifdef RECEIVE_DATA_VALID_EN
        if (data_valid !== 1'b0) vld_bad++;
`endif
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            load_sr = hold_load || (i == restrobe_at);
            dout_sr = tx_bits[i];
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                checks++;
                if (dout !== '0) begin
                    errors++;
                    $display("FAIL %s abort_clear: dout=%h required 0", name, dout);
                end
`ifdef RECEIVE_DATA_VALID_EN
                @(posedge clk);
                #1;
                if (data_valid !== 1'b0) vld_bad++;
                checks++;
                if (vld_bad !== 0) begin
                    errors++;
                    $display("FAIL %s abort_valid: data_valid high %0d times, required 0", name, vld_bad);
                end
`else
                @(posedge clk);
`endif
                model_dout = '0;
                @(negedge clk);
                rst     = 1'b0;
                load_sr = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i < W - 1) begin
                if (dout !== model_dout) hold_bad++;
`ifdef RECEIVE_DATA_VALID_EN
                if (data_valid !== 1'b0) vld_bad++;
`endif
            end
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL %s hold: dout changed early in %0d cycles, required 0", name, hold_bad);
        end
        checks++;
        if (dout !== exp_word) begin
            errors++;
            $display("FAIL %s word: dout=%h required %h", name, dout, exp_word);
        end
`ifdef RECEIVE_DATA_VALID_EN
        checks++;
        if (vld_bad !== 0 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: early pulses=%0d final=%b required 0 and 1", name, vld_bad, data_valid);
        end
`endif
        model_dout = exp_word;
    endtask

    task automatic test_reset();
        int idle_bad;
        rst     = 1'b1;
        load_sr = 1'b0;
        dout_sr = 1'b0;
        #1;
        checks++;
        if (dout !== '0) begin
            errors++;
            $display("FAIL reset_async: dout=%h required 0", dout);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            dout_sr = ~dout_sr;
            @(posedge clk);
            #1;
            checks++;
            if (dout !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: dout=%h required 0", c, dout);
            end
`ifdef RECEIVE_DATA_VALID_EN
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: data_valid=%b required 0", data_valid);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        idle_bad = 0;
        for (int c = 0; c < W + 5; c++) begin
            @(negedge clk);
            dout_sr = 1'($urandom);
            @(posedge clk);
            #1;
            if (dout !== '0) idle_bad++;
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL reset_no_capture: dout nonzero in %0d cycles, required 0", idle_bad);
        end
        model_dout = '0;
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < W; i++) tx_bits[i] = 1'b0;
        tx_bits[0] = 1'b1;
        tx_bits[2] = 1'b1;
        tx_bits[3] = 1'b1;
        run_frame("basic", 1'b0, -1, -1);
        checks++;
        if (dout[169] !== 1'b1 || dout[168] !== 1'b0 || dout[167:166] !== 2'b11 || dout[165:0] !== '0) begin
            errors++;
            $display("FAIL basic_fields: dout=%h required 2c followed by zeros", dout);
        end
    endtask

    task automatic test_ones_then_alternating();
        for (int i = 0; i < W; i++) tx_bits[i] = 1'b1;
        run_frame("all_ones", 1'b0, -1, -1);
        for (int i = 0; i < W; i++) tx_bits[i] = (i % 2 == 0);
        run_frame("alternating", 1'b0, -1, -1);
        checks++;
        if (dout[169] !== 1'b1 || dout[0] !== 1'b0) begin
            errors++;
            $display("FAIL alt_ends: dout[169]=%b dout[0]=%b required 1 and 0", dout[169], dout[0]);
        end
    endtask

    task automatic test_strobe_during_capture();
        int idle_bad;
        fill_random();
        run_frame("restrobe", 1'b0, 49, -1);
        idle_bad = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            load_sr = 1'b0;
            dout_sr = 1'($urandom);
            @(posedge clk);
            #1;
            if (dout !== model_dout) idle_bad++;
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL restrobe_idle: dout changed in %0d idle cycles, required 0", idle_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        run_frame("abort", 1'b0, -1, 100);
        fill_random();
        run_frame("after_abort", 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_frame("held_first", 1'b1, -1, -1);
        fill_random();
        run_frame("held_second", 1'b1, -1, -1);
        @(negedge clk);
        load_sr = 1'b0;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame("random", 1'b0, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ones_then_alternating();
        test_strobe_during_capture();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receive_data.md
# receive_data

Serial-to-parallel capture block for the test-chip shift-register readback path. After a one-cycle `load_sr` strobe, the block samples `WIDTH` consecutive bits from the chip's serial output `dout_sr`, MSB first, one bit per `clk` rising edge. It then presents the assembled word on `dout` in a single update. It sits between the chip's shift-register output pin and the register/readout logic that consumes the 170-bit configuration image.

## Interface
- `WIDTH`, default 170: number of bits captured per frame, and the width of `dout`. Legal range is 2 or more.
- `clk` input, 1 bit: single system clock. All logic samples on its rising edge.
- `rst` input, 1 bit: reset. Asynchronous and active-high.
- `dout_sr` input, 1 bit: serial data from the chip shift register, sampled on the rising edge of `clk`.
- `load_sr` input, 1 bit: frame-start strobe. A high sample while idle starts a capture.
- `dout` output, `WIDTH` bits: last completed frame. Bit `WIDTH-1` holds the first bit received.

## Operation
- The FSM has two states: `IDLE` and `SHIFT`.
- **In `IDLE`:** when `load_sr` is sampled 1, clear the bit counter and go to `SHIFT`. Nothing is shifted on this edge.
- **Each edge in `SHIFT`:**
  - Update the internal shift register as `sr <= {sr[WIDTH-2:0], dout_sr}`.
  - Increment the counter.
- **On the edge that shifts the `WIDTH`-th bit:**
  - Load `dout` with `{sr[WIDTH-2:0], dout_sr}`.
  - Return to `IDLE`.
- `dout` keeps the previous frame for the whole capture. Partial data is never visible on `dout`.
- `load_sr` is ignored in `SHIFT`. A strobe that arrives during a capture does not restart it.
- A strobe held for several cycles starts exactly one capture. After that capture completes, a still-high `load_sr` starts another one.
- The counter is `$clog2(WIDTH+1)` bits wide and saturates conceptually at `WIDTH`; it never wraps.
- **Reset:** asserting `rst` at any time, including mid-frame, forces:
  - state to `IDLE`
  - counter to 0
  - `sr` to 0
  - `dout` to 0
  
  The partial frame is discarded.

## Timing
- Let `load_sr` be sampled 1 at edge k while in `IDLE`:
  - Bit i, for i = 0..WIDTH-1, is sampled at edge k+1+i.
  - `dout` updates at edge k+WIDTH and is visible right after that edge.
- Latency from the strobe edge to new `dout` is `WIDTH` cycles. For the default width this is 170 cycles.
- The earliest next strobe is accepted at edge k+WIDTH+1.
- Reset values: `dout` = 0; internal state `IDLE`.
- There is no combinational path from inputs to outputs.

## Configuration
- **`RECEIVE_DATA_VALID_EN` defined:**
  - Adds output port `data_valid`, 1 bit.
  - It pulses high for exactly one cycle, in the cycle following the edge that updates `dout`.
  - It is 0 during reset.
- **`RECEIVE_DATA_VALID_EN` undefined:**
  - The port and its logic are absent.
  - The port list is exactly clk, rst, dout_sr, load_sr, dout.

## Structure
- Shared package `receive_data_pkg`:
  - `RECEIVE_DATA_WIDTH_DEFAULT` = 170
  - state enum `rx_state_t` {`RX_IDLE`, `RX_SHIFT`}
- Single module. The counter and shift register are simple enough that no sub-module is warranted.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `dout_sr` toggling -> `dout` = 0 throughout and after release. No capture starts without `load_sr`.
- **Basic frame:**
  - Stimulus: `load_sr`=1 for one cycle at edge k, then serial bits 1,0,1,1 followed by 166 zeros.
  - Required at edge k+170: `dout[169]`=1, `dout[168]`=0, `dout[167:166]`=2'b11, `dout[165:0]`=0.
  - `dout` stays 0 before edge k+170.
- **All-ones then alternating:**
  - First frame: 170 ones -> `dout` = all ones.
  - Second frame: 1010... -> `dout[169]`=1, `dout[0]`=0.
  - Between the frames, `dout` holds all ones during the entire second capture.
- **Strobe during capture:** pulse `load_sr` again 50 cycles into a frame -> that pulse is ignored and the frame completes at the original edge k+170.
- **Reset mid-frame:**
  - Assert `rst` 100 cycles into a frame -> `dout`=0 immediately.
  - Then issue a new strobe and a full frame -> correct word after 170 cycles, with no residue from the aborted bits.
- **`RECEIVE_DATA_VALID_EN` build:** `data_valid` is high for exactly one cycle per completed frame and never high after an aborted frame.
